// File: rtl/add_req_sequencer_if.sv
// Handshake and data bundle around the add request sequencer.
// slave  = the sequencer itself.
// master = its surroundings: the request source, the adder and the result consumer.
interface add_req_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 6
);
  // request channel
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  // adder channel
  logic             add_en;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic             add_ready;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  // result channel
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;
  logic             res_zero;
  logic             res_err;
  logic [CW-1:0]    res_cycles;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, add_ready, add_sum, add_cout, res_ready,
    output req_ready, add_en, add_a, add_b, add_cin,
           res_valid, res_sum, res_cout, res_ovf, res_zero, res_err, res_cycles
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, add_ready, add_sum, add_cout, res_ready,
    input  req_ready, add_en, add_a, add_b, add_cin,
           res_valid, res_sum, res_cout, res_ovf, res_zero, res_err, res_cycles
  );
endinterface

// File: rtl/add_req_sequencer.sv
// Issue stage in front of ripple_cla16. It takes one operand request, holds the
// operands and en steady until the adder reports ready, then captures and holds
// the result until the consumer takes it. A watchdog turns a stalled adder into
// an error result.
module add_req_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 32,
  parameter int CW      = 6
) (
  input logic                 clk,
  input logic                 reset,
  add_req_sequencer_if.slave  bus
);

  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    wdog;
  logic             add_en;
  logic [WIDTH-1:0] add_a, add_b;
  logic             add_cin;
  logic             res_valid;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout, res_ovf, res_zero, res_err;
  logic [CW-1:0]    res_cycles;

  // RUN leaves on adder ready or on watchdog expiry; ready wins when both occur on one edge.
  logic run_hit, run_to;
  assign run_hit = (state == RUN) && bus.add_ready;
  assign run_to  = (state == RUN) && !bus.add_ready && (wdog == TO);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid)       state_nxt = RUN;
      RUN:     if (run_hit || run_to)   state_nxt = DONE;
      DONE:    if (bus.res_ready)       state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // operand latch, adder enable and watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_en  <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      wdog    <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        add_a   <= bus.req_a;
        add_b   <= bus.req_b;
        add_cin <= bus.req_cin;
        add_en  <= 1'b1;
        wdog    <= CW'(1);
      end else if (run_hit || run_to) begin
        add_en  <= 1'b0;
      end else if (state == RUN) begin
        wdog    <= wdog + CW'(1);
      end
    end
  end

  // result capture and hold; overflow is judged on the latched operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_ovf    <= 1'b0;
      res_zero   <= 1'b0;
      res_err    <= 1'b0;
      res_cycles <= '0;
    end else begin
      if (run_hit) begin
        res_valid  <= 1'b1;
        res_sum    <= bus.add_sum;
        res_cout   <= bus.add_cout;
        res_ovf    <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                      (bus.add_sum[WIDTH-1] != add_a[WIDTH-1]);
        res_zero   <= (bus.add_sum == '0);
        res_err    <= 1'b0;
        res_cycles <= wdog;
      end else if (run_to) begin
        res_valid  <= 1'b1;
        res_sum    <= '0;
        res_cout   <= 1'b0;
        res_ovf    <= 1'b0;
        res_zero   <= 1'b0;
        res_err    <= 1'b1;
        res_cycles <= TO;
      end else if (state == DONE && bus.res_ready) begin
        res_valid  <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.add_en     = add_en;
  assign bus.add_a      = add_a;
  assign bus.add_b      = add_b;
  assign bus.add_cin    = add_cin;
  assign bus.res_valid  = res_valid;
  assign bus.res_sum    = res_sum;
  assign bus.res_cout   = res_cout;
  assign bus.res_ovf    = res_ovf;
  assign bus.res_zero   = res_zero;
  assign bus.res_err    = res_err;
  assign bus.res_cycles = res_cycles;

endmodule

// File: tb/tb_add_req_sequencer.sv
// Randomized bench for add_req_sequencer: a latency-programmable adder model
// drives the adder channel; expected results come from plain 17-bit arithmetic
// on the requested operands.
module tb_add_req_sequencer;
  localparam int WIDTH = 16, TIMEOUT = 32, CW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  add_req_sequencer_if #(.WIDTH(WIDTH), .CW(CW)) bus();

  add_req_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // adder model: ready on the lat_cur-th edge with en high; lat_cur==0 never answers
  int   lat_cur = 0;
  int   en_cnt  = 0;
  logic stray_ready = 1'b0;
  logic [WIDTH:0] full;

  always @(posedge clk or posedge reset) begin
    if (reset)           en_cnt <= 0;
    else if (bus.add_en) en_cnt <= en_cnt + 1;
    else                 en_cnt <= 0;
  end

  assign full          = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{WIDTH{1'b0}}, bus.add_cin};
  assign bus.add_sum   = full[WIDTH-1:0];
  assign bus.add_cout  = full[WIDTH];
  assign bus.add_ready = (bus.add_en && lat_cur != 0 && en_cnt == lat_cur - 1) || stray_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation: request, wait for result, check it, hold it for `hold`
  // cycles with a competing request and a stray adder ready, then release.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input int lat, input int hold);
    logic [WIDTH:0] ref_full;
    logic [WIDTH-1:0] e_sum;
    logic e_cout, e_ovf, e_zero, e_err;
    int   e_cyc, en_cycles;
    bit   done;

    ref_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    if (lat >= 1 && lat <= TIMEOUT) begin
      e_sum  = ref_full[WIDTH-1:0];
      e_cout = ref_full[WIDTH];
      e_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (e_sum[WIDTH-1] != a[WIDTH-1]);
      e_zero = (e_sum == 0);
      e_err  = 1'b0;
      e_cyc  = lat;
    end else begin
      e_sum = 0; e_cout = 0; e_ovf = 0; e_zero = 0; e_err = 1'b1;
      e_cyc = TIMEOUT;
    end

    lat_cur       = lat;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
    bus.req_valid = 1'b1;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;

    en_cycles = 0;
    done      = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.add_en) en_cycles++;
      if (bus.res_valid) done = 1;
    end
    chk("res_valid_seen", 32'(done), 32'd1);
    if (!done) return;

    chk("add_en_cycles", 32'(en_cycles), 32'(e_cyc));
    chk("res_sum",    32'(bus.res_sum),    32'(e_sum));
    chk("res_cout",   32'(bus.res_cout),   32'(e_cout));
    chk("res_ovf",    32'(bus.res_ovf),    32'(e_ovf));
    chk("res_zero",   32'(bus.res_zero),   32'(e_zero));
    chk("res_err",    32'(bus.res_err),    32'(e_err));
    chk("res_cycles", 32'(bus.res_cycles), 32'(e_cyc));

    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      stray_ready   = 1'b1;
      @(negedge clk);
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_sum",   32'(bus.res_sum),   32'(e_sum));
      chk("hold_err",   32'(bus.res_err),   32'(e_err));
      chk("hold_cyc",   32'(bus.res_cycles), 32'(e_cyc));
      chk("hold_rrdy",  32'(bus.req_ready), 32'd0);
      chk("hold_en",    32'(bus.add_en),    32'd0);
    end
    bus.req_valid = 1'b0;
    stray_ready   = 1'b0;

    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("post_valid", 32'(bus.res_valid), 32'd0);
    chk("post_rrdy",  32'(bus.req_ready), 32'd1);
    chk("post_en",    32'(bus.add_en),    32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 1'b0;
    bus.res_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rrdy",  32'(bus.req_ready),  32'd1);
    chk("rst_en",    32'(bus.add_en),     32'd0);
    chk("rst_a",     32'(bus.add_a),      32'd0);
    chk("rst_valid", 32'(bus.res_valid),  32'd0);
    chk("rst_sum",   32'(bus.res_sum),    32'd0);
    chk("rst_cyc",   32'(bus.res_cycles), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // directed cases
    run_op(16'd127,  16'd127,  1'b0, 8, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 3, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1, 0);
    run_op(16'h8000, 16'h8000, 1'b1, 2, 0);
    run_op(16'h1234, 16'h4321, 1'b1, 0, 0);        // adder never answers
    run_op(16'h00FF, 16'h0F00, 1'b0, TIMEOUT, 0);  // ready on the final edge
    run_op(16'h00FF, 16'h0F00, 1'b0, TIMEOUT + 1, 0);
    run_op(16'h5555, 16'hAAAA, 1'b1, 4, 5);        // consumer stall

    // reset in the middle of RUN
    lat_cur       = 20;
    bus.req_a     = 16'h0101;
    bus.req_b     = 16'h0202;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_en_before", 32'(bus.add_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_en_async",    32'(bus.add_en),    32'd0);
    chk("mid_valid_async", 32'(bus.res_valid), 32'd0);
    chk("mid_rrdy_async",  32'(bus.req_ready), 32'd1);
    #1 reset = 1'b0;
    @(negedge clk);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 6, 0);

    // random back-to-back traffic
    for (int k = 0; k < 10; k++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(1, 12)),
             int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
